// File: rtl/trace_serialiser_pkg.sv
// Shared types and constants for the trace serialiser: FSM state encoding,
// frame sync marker and the default upstream response timeout.
package trace_serialiser_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRequest,
    StWaitData,
    StSendSync,
    StSendData,
    StSendCsum
  } state_e;

  localparam logic [7:0] SYNC_BEAT = 8'hA5;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 8;

endpackage

// File: rtl/trace_serialiser.sv
// Pulls one trace element from an upstream buffer and emits it as a framed beat stream:
// SYNC, data beats LSB first, XOR checksum (tx_last). All outputs are registered.
module trace_serialiser
  import trace_serialiser_pkg::*;
#(
  parameter int unsigned TRACE_WIDTH    = 32,
  parameter int unsigned BEAT_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   data_present,
  input  logic                   data_valid,
  input  logic [TRACE_WIDTH-1:0] trace_element,
  output logic                   data_request,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic [BEAT_WIDTH-1:0]  tx_data,
  output logic                   tx_last,
  output logic                   busy,
  output logic [7:0]             frame_count,
  output logic                   timeout_err
);

  localparam int unsigned Beats = TRACE_WIDTH / BEAT_WIDTH;
  localparam int unsigned IdxW  = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int unsigned WaitW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_e                 state_q, state_d;
  logic [TRACE_WIDTH-1:0] elem_q, elem_d;
  logic [BEAT_WIDTH-1:0]  csum_q, csum_d;
  logic [IdxW-1:0]        beat_idx_q, beat_idx_d;
  logic [WaitW-1:0]       wait_cnt_q, wait_cnt_d;

  logic                   data_request_q, data_request_d;
  logic                   tx_valid_q, tx_valid_d;
  logic [BEAT_WIDTH-1:0]  tx_data_q, tx_data_d;
  logic                   tx_last_q, tx_last_d;
  logic                   busy_q, busy_d;
  logic [7:0]             frame_count_q, frame_count_d;
  logic                   timeout_err_q, timeout_err_d;

  logic                   tx_fire;

  assign tx_fire = tx_valid_q & tx_ready;

  always_comb begin
    state_d       = state_q;
    elem_d        = elem_q;
    csum_d        = csum_q;
    beat_idx_d    = beat_idx_q;
    wait_cnt_d    = wait_cnt_q;
    tx_valid_d    = tx_valid_q;
    tx_data_d     = tx_data_q;
    tx_last_d     = tx_last_q;
    frame_count_d = frame_count_q;
    timeout_err_d = timeout_err_q;

    unique case (state_q)
      StIdle: begin
        if (data_present) state_d = StRequest;
      end
      StRequest: begin
        wait_cnt_d = '0;
        state_d    = StWaitData;
      end
      StWaitData: begin
        if (data_valid) begin
          elem_d     = trace_element;
          csum_d     = '0;
          beat_idx_d = '0;
          tx_valid_d = 1'b1;
          tx_data_d  = BEAT_WIDTH'(SYNC_BEAT);
          tx_last_d  = 1'b0;
          state_d    = StSendSync;
        end else if (wait_cnt_q == WaitW'(TIMEOUT_CYCLES - 1)) begin
          timeout_err_d = 1'b1;
          state_d       = StIdle;
        end else begin
          wait_cnt_d = wait_cnt_q + WaitW'(1);
        end
      end
      StSendSync: begin
        if (tx_fire) begin
          tx_data_d = elem_q[BEAT_WIDTH-1:0];
          elem_d    = elem_q >> BEAT_WIDTH;
          state_d   = StSendData;
        end
      end
      StSendData: begin
        // The beat in tx_data_q is folded into the checksum as it transfers.
        if (tx_fire) begin
          csum_d = csum_q ^ tx_data_q;
          if (beat_idx_q == IdxW'(Beats - 1)) begin
            tx_data_d = csum_q ^ tx_data_q;
            tx_last_d = 1'b1;
            state_d   = StSendCsum;
          end else begin
            beat_idx_d = beat_idx_q + IdxW'(1);
            tx_data_d  = elem_q[BEAT_WIDTH-1:0];
            elem_d     = elem_q >> BEAT_WIDTH;
          end
        end
      end
      StSendCsum: begin
        if (tx_fire) begin
          frame_count_d = frame_count_q + 8'd1;
          tx_valid_d    = 1'b0;
          tx_last_d     = 1'b0;
          tx_data_d     = '0;
          state_d       = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    data_request_d = (state_d == StRequest);
    busy_d         = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      elem_q         <= '0;
      csum_q         <= '0;
      beat_idx_q     <= '0;
      wait_cnt_q     <= '0;
      data_request_q <= 1'b0;
      tx_valid_q     <= 1'b0;
      tx_data_q      <= '0;
      tx_last_q      <= 1'b0;
      busy_q         <= 1'b0;
      frame_count_q  <= '0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      elem_q         <= elem_d;
      csum_q         <= csum_d;
      beat_idx_q     <= beat_idx_d;
      wait_cnt_q     <= wait_cnt_d;
      data_request_q <= data_request_d;
      tx_valid_q     <= tx_valid_d;
      tx_data_q      <= tx_data_d;
      tx_last_q      <= tx_last_d;
      busy_q         <= busy_d;
      frame_count_q  <= frame_count_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  assign data_request = data_request_q;
  assign tx_valid     = tx_valid_q;
  assign tx_data      = tx_data_q;
  assign tx_last      = tx_last_q;
  assign busy         = busy_q;
  assign frame_count  = frame_count_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_trace_serialiser.sv
// Scoreboard bench for trace_serialiser: an upstream responder pushes expected frames,
// a negedge monitor pops and compares every transferred beat.
module tb_trace_serialiser;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic        clk;
  logic        rst;
  logic        data_present;
  logic        data_valid;
  logic [31:0] trace_element;
  logic        data_request;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        tx_last;
  logic        busy;
  logic [7:0]  frame_count;
  logic        timeout_err;

  logic        resp_dv, noise_dv;
  logic [31:0] resp_elem, noise_elem;
  logic        resp_en, noise_en;
  int unsigned resp_delay;
  int unsigned ready_mode;

  beat_t       exp_q[$];
  int          n_checks, n_errors;
  logic [7:0]  exp_fc;
  logic [7:0]  last_beat;

  assign data_valid    = resp_dv | noise_dv;
  assign trace_element = resp_dv ? resp_elem : noise_elem;

  trace_serialiser #(
    .TRACE_WIDTH   (32),
    .BEAT_WIDTH    (8),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .data_present (data_present),
    .data_valid   (data_valid),
    .trace_element(trace_element),
    .data_request (data_request),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_data      (tx_data),
    .tx_last      (tx_last),
    .busy         (busy),
    .frame_count  (frame_count),
    .timeout_err  (timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [31:0] e);
    logic [7:0] cs;
    logic [7:0] b;
    cs = 8'h00;
    exp_q.push_back('{data: 8'hA5, last: 1'b0});
    for (int i = 0; i < 4; i++) begin
      b  = e[8*i +: 8];
      cs = cs ^ b;
      exp_q.push_back('{data: b, last: 1'b0});
    end
    exp_q.push_back('{data: cs, last: 1'b1});
  endtask

  // Upstream buffer model: answers each request resp_delay cycles later.
  initial begin
    resp_dv = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (data_request && !rst) begin
        @(posedge clk);
        #1;
        check_eq("req_one_cycle", data_request, 0);
        if (resp_en) begin
          repeat (resp_delay - 1) @(posedge clk);
          #1;
          resp_dv = 1'b1;
          push_frame(resp_elem);
          @(posedge clk);
          #1;
          resp_dv = 1'b0;
          check_eq("sync_after_capture", tx_valid, 1);
        end
      end
    end
  end

  // Stray data_valid pulses while a frame is on the wire must be ignored.
  initial begin
    noise_dv   = 1'b0;
    noise_elem = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (noise_en && tx_valid && !resp_dv) begin
        noise_dv   = $urandom_range(0, 1) != 0;
        noise_elem = $urandom;
      end else begin
        noise_dv = 1'b0;
      end
    end
  end

  initial begin
    int ph;
    ph       = 0;
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1: begin
          tx_ready = (ph == 0);
          ph       = (ph + 1) % 3;
        end
        2:       tx_ready = $urandom_range(0, 1) != 0;
        default: tx_ready = 1'b1;
      endcase
    end
  end

  initial begin
    beat_t      b;
    logic       stall;
    logic [7:0] stall_data;
    stall      = 1'b0;
    stall_data = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          check_eq("hold_valid", tx_valid, 1);
          check_eq("hold_data", tx_data, stall_data);
        end
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            check_eq("unexpected_beat", tx_valid, 0);
          end else begin
            b = exp_q.pop_front();
            check_eq("beat_data", tx_data, b.data);
            check_eq("beat_last", tx_last, b.last);
            last_beat = tx_data;
          end
        end
        stall      = tx_valid && !tx_ready;
        stall_data = tx_data;
      end
    end
  end

  task automatic wait_request();
    for (int i = 0; i < 20 && !data_request; i++) begin
      @(posedge clk);
      #1;
    end
    check_eq("request_seen", data_request, 1);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy; i++) begin
      @(posedge clk);
      #1;
    end
    check_eq("busy_clear", busy, 0);
  endtask

  task automatic run_frame(input logic [31:0] e);
    resp_elem    = e;
    resp_en      = 1'b1;
    data_present = 1'b1;
    wait_request();
    data_present = 1'b0;
    wait_idle(300);
    exp_fc = exp_fc + 8'd1;
    check_eq("frame_count", frame_count, exp_fc);
    check_eq("queue_drained", exp_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_req"}, data_request, 0);
    check_eq({tag, "_valid"}, tx_valid, 0);
    check_eq({tag, "_last"}, tx_last, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_terr"}, timeout_err, 0);
    check_eq({tag, "_data"}, tx_data, 0);
    check_eq({tag, "_fc"}, frame_count, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    n_checks     = 0;
    n_errors     = 0;
    exp_fc       = 8'd0;
    last_beat    = 8'h00;
    rst          = 1'b1;
    data_present = 1'b0;
    resp_en      = 1'b1;
    noise_en     = 1'b0;
    resp_delay   = 2;
    resp_elem    = 32'h0;
    ready_mode   = 0;
    #1;
    check_all_zero("reset");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic frame, also timing the burst from SYNC to checksum transfer.
    resp_elem    = 32'h11223344;
    data_present = 1'b1;
    wait_request();
    data_present = 1'b0;
    for (int i = 0; i < 20 && !tx_valid; i++) begin
      @(posedge clk);
      #1;
    end
    check_eq("first_valid", tx_valid, 1);
    cyc = 0;
    while (busy && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check_eq("burst_cycles", cyc, 6);
    exp_fc = exp_fc + 8'd1;
    check_eq("basic_fc", frame_count, exp_fc);
    check_eq("basic_terr", timeout_err, 0);
    check_eq("basic_drained", exp_q.size(), 0);

    // Backpressure 1,0,0 pattern.
    ready_mode = 1;
    run_frame(32'h11223344);
    ready_mode = 0;

    // Upstream never answers.
    resp_en      = 1'b0;
    data_present = 1'b1;
    wait_request();
    data_present = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_eq("timeout_not_early", busy, 1);
    wait_idle(12);
    check_eq("timeout_err_set", timeout_err, 1);
    check_eq("timeout_no_valid", tx_valid, 0);
    check_eq("timeout_fc", frame_count, exp_fc);
    run_frame(32'hCAFE0123);
    check_eq("timeout_sticky", timeout_err, 1);

    // Reset while the 0x22 beat is pending (0x33 already transferred).
    resp_elem    = 32'h11223344;
    data_present = 1'b1;
    wait_request();
    data_present = 1'b0;
    for (int i = 0; i < 30 && !(tx_valid && tx_data == 8'h22); i++) begin
      @(posedge clk);
      #1;
    end
    check_eq("reached_beat_22", tx_data, 8'h22);
    rst = 1'b1;
    #1;
    check_all_zero("midreset");
    exp_q.delete();
    exp_fc = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    run_frame(32'hDEADBEEF);
    check_eq("deadbeef_csum", last_beat, 8'h22);

    // 256 frames with random elements, random ready and stray data_valid pulses.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    exp_fc = 8'd0;
    check_eq("wrap_start_fc", frame_count, 0);
    ready_mode = 2;
    noise_en   = 1'b1;
    for (int f = 0; f < 256; f++) begin
      resp_delay = 1 + (f % 3);
      run_frame($urandom);
    end
    noise_en   = 1'b0;
    ready_mode = 0;
    check_eq("wrap_fc_zero", frame_count, 0);

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
